cc_miss_fill: RTL and testbench

Miss-handling refill engine of the cache controller; write-side counterpart of the tag lookup.
- Consumes a one-cycle miss pulse plus the delayed tag/index/offset that accompany it.
- Fetches the full 64-byte line from memory over an AXI-style read-address/read-data channel.
- Writes the line into the data SRAM and {valid=1, tag} into the tag SRAM.
- Returns the requested 32-bit word to the requester with a one-cycle response pulse.

---
 rtl/cc_pkg.sv | 36 +++
 rtl/cc_miss_fill_if.sv | 26 ++
 rtl/cc_line_buffer.sv | 48 ++++
 rtl/cc_miss_fill.sv | 162 ++++++++++++++++
 tb/tb_cc_miss_fill.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cc_pkg.sv
// Shared cache-controller constants and types: geometry of the tag/index/offset
// split, the refill bus width and the miss-fill state encoding.
package cc_pkg;

   localparam int unsigned TAG_W      = 18;
   localparam int unsigned IDX_W      = 8;
   localparam int unsigned OFF_W      = 6;
   localparam int unsigned LINE_BYTES = 64;
   localparam int unsigned LINE_W     = LINE_BYTES * 8;
   localparam int unsigned BUS_W      = 128;
   localparam int unsigned BEATS      = LINE_W / BUS_W;
   localparam int unsigned CNT_W      = $clog2(BEATS);
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned WSEL_W     = OFF_W - 2;
   localparam int unsigned ADDR_W     = TAG_W + IDX_W + OFF_W;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_e;

   // Line-aligned memory address for a tag/index pair.
   function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
      return {tag, idx, {OFF_W{1'b0}}};
   endfunction

   // Index of the 32-bit word inside the line; the byte-within-word bits drop out.
   function automatic logic [WSEL_W-1:0] word_index(input logic [OFF_W-1:0] off);
      return off[OFF_W-1:2];
   endfunction

endpackage

// File: rtl/cc_miss_fill_if.sv
// AXI-style read-address / read-data channel between the refill engine (master)
// and the memory side (slave).
interface cc_miss_fill_if;
   import cc_pkg::*;

   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic              arvalid;
   logic              arready;
   logic [BUS_W-1:0]  rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   modport master (
      output araddr, arlen, arvalid, rready,
      input  arready, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  araddr, arlen, arvalid, rready,
      output arready, rdata, rresp, rlast, rvalid
   );

endinterface

// File: rtl/cc_line_buffer.sv
// Refill line buffer: BEATS x BUS_W registers written one beat at a time.
// Exposes the line as it will stand after the current write (so the final beat
// can be committed to the SRAM in the same edge it arrives) and a 32-bit word
// select over the stored line.
module cc_line_buffer
   import cc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic [CNT_W-1:0]  wr_beat_i,
   input  logic [BUS_W-1:0]  wr_data_i,
   input  logic [WSEL_W-1:0] word_sel_i,
   output logic [LINE_W-1:0] line_d_o,
   output logic [WORD_W-1:0] word_o
);

   logic [BUS_W-1:0]  beat_q [BEATS];
   logic [LINE_W-1:0] line_s;

   // Store each accepted beat in its slot; cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < BEATS; b++) begin
            beat_q[b] <= '0;
         end
      end else if (wr_en_i) begin
         beat_q[wr_beat_i] <= wr_data_i;
      end
   end

   // Flatten stored beats, and the same line with this cycle's beat merged in.
   always_comb begin
      line_s   = '0;
      line_d_o = '0;
      for (int b = 0; b < BEATS; b++) begin
         line_s[b*BUS_W +: BUS_W] = beat_q[b];
         if (wr_en_i && (wr_beat_i == CNT_W'(b))) begin
            line_d_o[b*BUS_W +: BUS_W] = wr_data_i;
         end else begin
            line_d_o[b*BUS_W +: BUS_W] = beat_q[b];
         end
      end
   end

   assign word_o = line_s[word_sel_i * WORD_W +: WORD_W];

endmodule

// File: rtl/cc_miss_fill.sv
// Miss refill engine: captures a miss, bursts the 64-byte line in over the read
// channel, writes line and {valid, tag} to the SRAMs for one cycle, then pulses
// the requested word back. All outputs come straight from registers.
module cc_miss_fill
   import cc_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                miss_i,
   input  logic [TAG_W-1:0]    tag_i,
   input  logic [IDX_W-1:0]    index_i,
   input  logic [OFF_W-1:0]    offset_i,
   output logic                busy_o,
   cc_miss_fill_if.master      axi,
   output logic                tag_wren_o,
   output logic [IDX_W-1:0]    tag_waddr_o,
   output logic [TAG_W:0]      tag_wdata_o,
   output logic                data_wren_o,
   output logic [IDX_W-1:0]    data_waddr_o,
   output logic [LINE_W-1:0]   data_wdata_o,
   output logic                resp_valid_o,
   output logic [WORD_W-1:0]   resp_data_o,
   output logic                err_o
);

   state_e              state_q;
   logic [TAG_W-1:0]    tag_q;
   logic [IDX_W-1:0]    idx_q;
   logic [WSEL_W-1:0]   wsel_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                busy_q;
   logic [ADDR_W-1:0]   araddr_q;
   logic [7:0]          arlen_q;
   logic                arvalid_q;
   logic                rready_q;
   logic                tag_wren_q;
   logic [TAG_W:0]      tag_wdata_q;
   logic                data_wren_q;
   logic [LINE_W-1:0]   data_wdata_q;
   logic                resp_valid_q;
   logic [WORD_W-1:0]   resp_data_q;
   logic                err_q;

   logic                beat_s;
   logic                last_beat_s;
   logic                beat_err_s;
   logic [LINE_W-1:0]   line_d;
   logic [WORD_W-1:0]   word_s;

   assign beat_s      = (state_q == DATA) && rready_q && axi.rvalid;
   assign last_beat_s = (cnt_q == CNT_W'(BEATS - 1));
   // A bad response code or rlast on the wrong beat both count as bus errors.
   assign beat_err_s  = (axi.rresp != 2'b00) || (axi.rlast != last_beat_s);

   cc_line_buffer u_line_buffer (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (beat_s),
      .wr_beat_i  (cnt_q),
      .wr_data_i  (axi.rdata),
      .word_sel_i (wsel_q),
      .line_d_o   (line_d),
      .word_o     (word_s)
   );

   // Refill FSM with registered handshake, SRAM-write and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         tag_q        <= '0;
         idx_q        <= '0;
         wsel_q       <= '0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         araddr_q     <= '0;
         arlen_q      <= 8'h00;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         tag_wren_q   <= 1'b0;
         tag_wdata_q  <= '0;
         data_wren_q  <= 1'b0;
         data_wdata_q <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         // Enables and the response are single-cycle pulses.
         tag_wren_q   <= 1'b0;
         data_wren_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (miss_i) begin
                  tag_q     <= tag_i;
                  idx_q     <= index_i;
                  wsel_q    <= word_index(offset_i);
                  cnt_q     <= '0;
                  araddr_q  <= line_addr(tag_i, index_i);
                  arlen_q   <= 8'(BEATS - 1);
                  arvalid_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= REQ;
               end
            end
            REQ: begin
               if (axi.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= DATA;
               end
            end
            DATA: begin
               if (beat_s) begin
                  if (beat_err_s) begin
                     err_q <= 1'b1;
                  end
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (last_beat_s) begin
                     rready_q     <= 1'b0;
                     tag_wren_q   <= 1'b1;
                     tag_wdata_q  <= {1'b1, tag_q};
                     data_wren_q  <= 1'b1;
                     data_wdata_q <= line_d;
                     state_q      <= WRITE;
                  end
               end
            end
            WRITE: begin
               resp_valid_q <= 1'b1;
               resp_data_q  <= word_s;
               state_q      <= DONE;
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q    <= 1'b0;
               arvalid_q <= 1'b0;
               rready_q  <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign axi.araddr   = araddr_q;
   assign axi.arlen    = arlen_q;
   assign axi.arvalid  = arvalid_q;
   assign axi.rready   = rready_q;
   assign tag_wren_o   = tag_wren_q;
   assign tag_waddr_o  = idx_q;
   assign tag_wdata_o  = tag_wdata_q;
   assign data_wren_o  = data_wren_q;
   assign data_waddr_o = idx_q;
   assign data_wdata_o = data_wdata_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_data_o  = resp_data_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_cc_miss_fill.sv
// Directed bench for cc_miss_fill: a small memory responder feeds the burst,
// each fill is observed cycle by cycle and compared against hand-computed values.
module tb_cc_miss_fill;
   import cc_pkg::*;

   logic                clk;
   logic                rst_n;
   logic                miss_i;
   logic [TAG_W-1:0]    tag_i;
   logic [IDX_W-1:0]    index_i;
   logic [OFF_W-1:0]    offset_i;
   logic                busy_o;
   logic                tag_wren_o;
   logic [IDX_W-1:0]    tag_waddr_o;
   logic [TAG_W:0]      tag_wdata_o;
   logic                data_wren_o;
   logic [IDX_W-1:0]    data_waddr_o;
   logic [LINE_W-1:0]   data_wdata_o;
   logic                resp_valid_o;
   logic [WORD_W-1:0]   resp_data_o;
   logic                err_o;

   cc_miss_fill_if axi ();

   cc_miss_fill dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .miss_i       (miss_i),
      .tag_i        (tag_i),
      .index_i      (index_i),
      .offset_i     (offset_i),
      .busy_o       (busy_o),
      .axi          (axi),
      .tag_wren_o   (tag_wren_o),
      .tag_waddr_o  (tag_waddr_o),
      .tag_wdata_o  (tag_wdata_o),
      .data_wren_o  (data_wren_o),
      .data_waddr_o (data_waddr_o),
      .data_wdata_o (data_wdata_o),
      .resp_valid_o (resp_valid_o),
      .resp_data_o  (resp_data_o),
      .err_o        (err_o)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          busy_miss_cnt = 0;

   logic [31:0] cfg_base = 32'h0;
   int          cfg_ar_wait = 0;
   bit          cfg_toggle = 1'b0;
   int          cfg_rresp_beat = -1;
   int          cfg_rlast_beat = -1;

   int          beat = 0;
   int          ar_wait_left = 0;
   bit          ar_active = 1'b0;
   bit          tog = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] exp_line(input logic [31:0] base);
      logic [511:0] l;
      l = '0;
      for (int k = 0; k < 16; k++) begin
         l[k*32 +: 32] = base + 32'(k);
      end
      return l;
   endfunction

   // Memory responder: optional address-channel stall, optional 1-0 data toggling,
   // injected rresp / early rlast faults. Word k of the line is cfg_base + k.
   always @(negedge clk) begin
      if (!rst_n) begin
         axi.arready  = 1'b0;
         axi.rvalid   = 1'b0;
         axi.rlast    = 1'b0;
         axi.rresp    = 2'b00;
         axi.rdata    = '0;
         beat         = 0;
         ar_active    = 1'b0;
         ar_wait_left = 0;
         tog          = 1'b0;
      end else begin
         if (axi.arvalid) begin
            if (!ar_active) begin
               ar_active    = 1'b1;
               ar_wait_left = cfg_ar_wait;
               beat         = 0;
               tog          = 1'b0;
            end
            if (ar_wait_left > 0) begin
               axi.arready = 1'b0;
               ar_wait_left--;
            end else begin
               axi.arready = 1'b1;
            end
         end else begin
            ar_active   = 1'b0;
            axi.arready = 1'b0;
         end
         axi.rvalid = 1'b0;
         axi.rlast  = 1'b0;
         axi.rresp  = 2'b00;
         if (axi.rready && beat < 4) begin
            if (tog) begin
               tog = 1'b0;
            end else begin
               for (int w = 0; w < 4; w++) begin
                  axi.rdata[w*32 +: 32] = cfg_base + 32'(beat*4 + w);
               end
               axi.rvalid = 1'b1;
               axi.rlast  = (beat == 3) || (beat == cfg_rlast_beat);
               axi.rresp  = (beat == cfg_rresp_beat) ? 2'b10 : 2'b00;
               beat++;
               tog = cfg_toggle;
            end
         end
      end
   end

   task automatic pulse_miss(input logic [17:0] t, input logic [7:0] i, input logic [5:0] o);
      tag_i    = t;
      index_i  = i;
      offset_i = o;
      miss_i   = 1'b1;
      if (busy_o) busy_miss_cnt++;
      @(negedge clk); #1;
      miss_i = 1'b0;
   endtask

   task automatic chk_reset_outputs();
      chk_eq("rst_ctrl", {busy_o, axi.arvalid, axi.rready, tag_wren_o, data_wren_o,
                          resp_valid_o, err_o}, 7'b0);
      chk_eq("rst_araddr", {axi.araddr, axi.arlen}, 40'h0);
      chk_eq("rst_addrs", {tag_waddr_o, data_waddr_o, tag_wdata_o}, 35'h0);
      chk_eq("rst_resp_data", resp_data_o, 32'h0);
      chk_eq("rst_wdata", data_wdata_o, 512'h0);
   endtask

   task automatic run_fill(input logic [17:0] t, input logic [7:0] i, input logic [5:0] o,
                           input logic [31:0] base, input logic [31:0] exp_addr,
                           input logic [31:0] exp_resp, input int ar_wait, input bit toggle,
                           input int rresp_beat, input int rlast_beat, input int inject_cyc,
                           input int post, input bit exp_err, input bit chk_lat);
      int          cyc, n_tw, n_dw, n_resp, w_cyc, r_cyc, addr_bad;
      bit          seen_ar, done;
      logic [31:0] first_addr, resp_val;
      logic [7:0]  first_len, tw_addr, dw_addr;
      logic [18:0] tw_data;
      logic [511:0] dw_data;
      @(negedge clk); #1;
      cfg_base = base; cfg_ar_wait = ar_wait; cfg_toggle = toggle;
      cfg_rresp_beat = rresp_beat; cfg_rlast_beat = rlast_beat;
      pulse_miss(t, i, o);
      cyc = 1; n_tw = 0; n_dw = 0; n_resp = 0; w_cyc = 0; r_cyc = 0; addr_bad = 0;
      seen_ar = 1'b0; done = 1'b0;
      first_addr = '0; first_len = '0; tw_addr = '0; dw_addr = '0; tw_data = '0;
      dw_data = '0; resp_val = '0;
      while (!done && cyc < 200) begin
         if (axi.arvalid) begin
            if (!seen_ar) begin
               seen_ar = 1'b1; first_addr = axi.araddr; first_len = axi.arlen;
            end
            if (axi.araddr !== exp_addr) addr_bad++;
         end
         if (tag_wren_o) begin
            n_tw++; w_cyc = cyc; tw_addr = tag_waddr_o; tw_data = tag_wdata_o;
         end
         if (data_wren_o) begin
            n_dw++; dw_addr = data_waddr_o; dw_data = data_wdata_o;
         end
         if (resp_valid_o) begin
            n_resp++; r_cyc = cyc; resp_val = resp_data_o;
         end
         if (cyc == inject_cyc) begin
            tag_i = ~t; index_i = ~i; miss_i = 1'b1;
            if (busy_o) busy_miss_cnt++;
         end else begin
            miss_i = 1'b0;
         end
         if (n_resp > 0 && cyc >= r_cyc + post) begin
            done = 1'b1;
         end else begin
            @(negedge clk); #1;
            cyc++;
         end
      end
      miss_i = 1'b0;
      chk_eq("resp_seen", n_resp > 0, 1'b1);
      chk_eq("araddr", first_addr, exp_addr);
      chk_eq("arlen", first_len, 8'd3);
      chk_eq("araddr_stable", addr_bad, 0);
      chk_eq("wren_pulses", {n_tw[7:0], n_dw[7:0], n_resp[7:0]}, 24'h010101);
      chk_eq("tag_waddr", tw_addr, i);
      chk_eq("tag_wdata", tw_data, {1'b1, t});
      chk_eq("data_waddr", dw_addr, i);
      chk_eq("line", dw_data, exp_line(base));
      chk_eq("resp_data", resp_val, exp_resp);
      chk_eq("err", err_o, exp_err);
      if (chk_lat) begin
         chk_eq("wren_cycle", w_cyc, 6);
         chk_eq("resp_cycle", r_cyc, 7);
      end
      if (post >= 2) begin
         chk_eq("idle_after", {busy_o, axi.arvalid}, 2'b00);
      end
   endtask

   initial begin
      int k, n_w;
      rst_n = 1'b0; miss_i = 1'b0; tag_i = '0; index_i = '0; offset_i = '0;
      repeat (2) @(negedge clk);
      #1;
      chk_reset_outputs();
      rst_n = 1'b1;

      // Basic fill at minimum latency
      run_fill(18'h2A5A5, 8'h3C, 6'h24, 32'h1000_0000, 32'hA969_4F00, 32'h1000_0009,
               0, 1'b0, -1, -1, -1, 3, 1'b0, 1'b1);
      // Backpressure on both channels, plus a stray miss during DATA
      run_fill(18'h2A5A5, 8'h3C, 6'h24, 32'h1000_0000, 32'hA969_4F00, 32'h1000_0009,
               5, 1'b1, -1, -1, 9, 3, 1'b0, 1'b0);
      chk_eq("miss_in_data_flag", busy_miss_cnt, 1);
      // Offset 0, then a back-to-back miss in the first IDLE cycle with offset 3F
      run_fill(18'h00001, 8'hFF, 6'h00, 32'h2000_0000, 32'h0000_7FC0, 32'h2000_0000,
               0, 1'b0, -1, -1, -1, 0, 1'b0, 1'b1);
      run_fill(18'h3FFFF, 8'h00, 6'h3F, 32'h3000_0000, 32'hFFFF_C000, 32'h3000_000F,
               0, 1'b0, -1, -1, -1, 0, 1'b0, 1'b1);
      chk_eq("b2b_no_flag", busy_miss_cnt, 1);
      // Miss in the DONE cycle is dropped
      pulse_miss(18'h12345, 8'h81, 6'h10);
      chk_eq("done_miss_flag", busy_miss_cnt, 2);
      chk_eq("done_miss_ignored", {busy_o, axi.arvalid}, 2'b00);
      repeat (3) begin @(negedge clk); #1; end
      chk_eq("done_miss_still_idle", {busy_o, axi.arvalid}, 2'b00);
      // Bad response on beat 1, then a clean fill to show err_o is sticky
      run_fill(18'h2A5A5, 8'h3C, 6'h3C, 32'h5000_0000, 32'hA969_4F00, 32'h5000_000F,
               0, 1'b0, 1, -1, -1, 2, 1'b1, 1'b0);
      run_fill(18'h00001, 8'hFF, 6'h04, 32'h6000_0000, 32'h0000_7FC0, 32'h6000_0001,
               0, 1'b0, -1, -1, -1, 2, 1'b1, 1'b0);

      // Reset asynchronously after beat 2 has been taken
      @(negedge clk); #1;
      cfg_base = 32'h1000_0000; cfg_ar_wait = 0; cfg_toggle = 1'b0;
      cfg_rresp_beat = -1; cfg_rlast_beat = -1;
      pulse_miss(18'h2A5A5, 8'h3C, 6'h24);
      k = 0; n_w = 0;
      while (beat != 3 && k < 50) begin
         if (tag_wren_o || data_wren_o) n_w++;
         @(negedge clk); #1;
         k++;
      end
      chk_eq("rst_mid_reached", k < 50, 1'b1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      repeat (2) begin @(negedge clk); #1; if (tag_wren_o || data_wren_o) n_w++; end
      rst_n = 1'b1;
      repeat (3) begin @(negedge clk); #1; if (tag_wren_o || data_wren_o) n_w++; end
      chk_eq("rst_mid_no_write", n_w, 0);

      // Normal fill after reset, then rlast asserted early on beat 2
      run_fill(18'h2A5A5, 8'h3C, 6'h24, 32'h1000_0000, 32'hA969_4F00, 32'h1000_0009,
               0, 1'b0, -1, -1, -1, 2, 1'b0, 1'b1);
      run_fill(18'h12345, 8'h81, 6'h20, 32'h7000_0000, 32'h48D1_6040, 32'h7000_0008,
               0, 1'b0, -1, 2, -1, 3, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
